// File: rtl/dbf_pkg.sv
// Delay-and-sum beamformer: shared defaults, width helpers and saturation.
package dbf_pkg;

  localparam int DEF_LINES       = 4;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_SLOT_BITS   = 32;
  localparam int DEF_DEPTH       = 16;

  function automatic int nch(input int lines);
    return 2 * lines;
  endfunction

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(input int bits, input int n);
    return bits + addr_w(n);
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 bits
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dbf_delay_line.sv
// Single-channel circular sample buffer with combinational read port.
module dbf_delay_line
  import dbf_pkg::*;
#(
  parameter int W     = DEF_SAMPLE_BITS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  // Contents are deliberately not reset; the fill count masks stale entries.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/delay_sum_beamformer.sv
// I2S multi-line receiver, per-channel frame delay, enable-masked sum,
// and I2S retransmit of the saturated sum.
module delay_sum_beamformer
  import dbf_pkg::*;
#(
  parameter int NUM_LINES   = DEF_LINES,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_LINES-1:0]                     sd_in,
  output logic                                     ws_out,
  input  logic                                     cfg_we,
  input  logic [addr_w(nch(NUM_LINES))-1:0]        cfg_ch,
  input  logic [addr_w(DEPTH)-1:0]                 cfg_delay,
  input  logic                                     cfg_en,
  output logic [sum_w(SAMPLE_BITS,nch(NUM_LINES))-1:0] sum_out,
  output logic                                     sum_valid,
  output logic                                     sd_out
);

  localparam int NCH = nch(NUM_LINES);
  localparam int CW  = addr_w(NCH);
  localparam int DW  = addr_w(DEPTH);
  localparam int SB  = SAMPLE_BITS;
  localparam int SW  = sum_w(SAMPLE_BITS, NCH);
  localparam int FW  = addr_w(2 * SLOT_BITS);

  localparam logic [FW-1:0] LAST = FW'(2 * SLOT_BITS - 1);
  localparam logic [FW-1:0] SLOT = FW'(SLOT_BITS);
  localparam logic [FW-1:0] SBF  = FW'(SAMPLE_BITS);
  localparam logic [DW:0]   FULL = (DW + 1)'(DEPTH);

  logic [FW-1:0] fcnt;
  logic [FW-1:0] off;
  logic          ws;
  logic          fend;
  logic          win;
  logic          wr_done;
  logic          cfg_ok;

  logic [DW-1:0] wp;
  logic [DW:0]   fill;
  logic [DW:0]   fill_nx;

  logic [SB-1:0] sh    [NCH];
  logic [SB-1:0] sh_nx [NCH];
  logic [SB-1:0] rd    [NCH];
  logic [DW-1:0] ra    [NCH];
  logic [DW-1:0] dly    [NCH];
  logic [DW-1:0] dly_sh [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] en_sh;

  logic signed [SW-1:0] acc;
  logic [SB-1:0]        tx;

  assign ws   = fcnt >= SLOT;
  assign fend = fcnt == LAST;
  assign off  = ws ? fcnt - SLOT : fcnt;
  assign win  = (off != '0) && (off <= SBF);

  assign fill_nx = (fill == FULL) ? fill : fill + 1'b1;

  generate
    if (NCH == (1 << CW)) begin : g_cfg_all
      assign cfg_ok = cfg_we;
    end else begin : g_cfg_chk
      assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < (CW + 1)'(NCH));
    end
  endgenerate

  // Current slot's channel shifts MSB first during the sample window.
  always_comb begin
    sh_nx = sh;
    if (win) begin
      for (int l = 0; l < NUM_LINES; l++) begin
        sh_nx[2*l + (ws ? 1 : 0)] =
          {sh[2*l + (ws ? 1 : 0)][SB-2:0], sd_in[l]};
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ra[c] = wp - dly[c] - DW'(1);
    end
  end

  // wp has already advanced here, hence the extra -1 on the read address.
  always_comb begin
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      if (en[c] && ({1'b0, dly[c]} < fill)) begin
        acc = acc + {{CW{rd[c][SB-1]}}, rd[c]};
      end
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_line
      dbf_delay_line #(
        .W     (SB),
        .DEPTH (DEPTH),
        .AW    (DW)
      ) u_line (
        .clk (clk),
        .we  (fend),
        .wa  (wp),
        .wd  (sh_nx[g]),
        .ra  (ra[g]),
        .rd  (rd[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt      <= '0;
      wp        <= '0;
      fill      <= '0;
      wr_done   <= 1'b0;
      sh        <= '{default: '0};
      dly       <= '{default: '0};
      dly_sh    <= '{default: '0};
      en        <= '1;
      en_sh     <= '1;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      tx        <= '0;
    end else begin
      fcnt      <= fend ? '0 : fcnt + 1'b1;
      sh        <= sh_nx;
      wr_done   <= fend;
      sum_valid <= wr_done;
      if (cfg_ok) begin
        dly_sh[cfg_ch] <= cfg_delay;
        en_sh[cfg_ch]  <= cfg_en;
      end
      if (fend) begin
        wp   <= wp + 1'b1;
        fill <= fill_nx;
        dly  <= dly_sh;
        en   <= en_sh;
      end
      if (wr_done) begin
        sum_out <= acc;
        tx      <= SB'(saturate({{(64-SW){acc[SW-1]}}, acc}, SAMPLE_BITS));
      end else if (!ws && win) begin
        tx <= {tx[SB-2:0], 1'b0};
      end
    end
  end

  assign ws_out = ~reset & ws;
  assign sd_out = ~reset & ~ws & win & tx[SB-1];

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Scoreboard bench for delay_sum_beamformer: directed frames,
// expected sums queued at issue and checked on sum_valid.
module tb_delay_sum_beamformer;
  import dbf_pkg::*;

  typedef logic [15:0] smp_t [8];
  typedef struct {
    int          sum;
    logic [15:0] sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sd_in = '0;
  logic        ws_out;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [3:0]  cfg_delay = '0;
  logic        cfg_en = 1'b0;
  logic [18:0] sum_out;
  logic        sum_valid;
  logic        sd_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   bpos  = 0;
  smp_t cur   = '{default: 16'h0000};
  exp_t exq[$];

  delay_sum_beamformer #(
    .NUM_LINES   (4),
    .SAMPLE_BITS (16),
    .SLOT_BITS   (32),
    .DEPTH       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sd_in     (sd_in),
    .ws_out    (ws_out),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .cfg_en    (cfg_en),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sd_out    (sd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bpos <= reset ? 0 : ((bpos == 63) ? 0 : bpos + 1);
  end

  // Ignored slot offsets carry 1s so a widened capture window shows up.
  always @(negedge clk) begin : drv
    int off;
    int sl;
    sl  = bpos / 32;
    off = bpos % 32;
    for (int l = 0; l < 4; l++) begin
      sd_in[l] = (off >= 1 && off <= 16) ? cur[2*l+sl][16-off] : 1'b1;
    end
  end

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] ramp(input int k);
    return 16'(256 * (k + 1) + k);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_pos(input int p);
    int g;
    g = 0;
    while (bpos != p && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pos %0d: timed out at pos %0d", p, bpos);
    end
  endtask

  task automatic frame(input smp_t s, input int sum, input bit chk);
    exp_t e;
    wait_pos(0);
    cur = s;
    if (chk) begin
      e.sum = sum;
      e.sat = sat16(sum);
      exq.push_back(e);
    end
    wait_pos(31);
    check("ws_out left", ws_out, 0);
    @(negedge clk);
    check("ws_out right", ws_out, 1);
  endtask

  task automatic cfg(input int ch, input int d, input bit e);
    cfg_ch    = 3'(ch);
    cfg_delay = 4'(d);
    cfg_en    = e;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_end(input int ch, input int d, input bit e);
    wait_pos(63);
    cfg(ch, d, e);
  endtask

  task automatic rst_check(input string tag);
    check({tag, " ws_out"}, ws_out, 0);
    check({tag, " sd_out"}, sd_out, 0);
    check({tag, " sum_valid"}, sum_valid, 0);
    check({tag, " sum_out"}, sum_out, 0);
  endtask

  initial begin : mon
    exp_t        e;
    logic [15:0] bits;
    int          s;
    forever begin
      @(negedge clk);
      if (sum_valid && !reset) begin
        if (exq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected sum_valid: got sum %0d, expected none",
                   $signed(sum_out));
        end else begin
          e = exq.pop_front();
          s = $signed(sum_out);
          check("sum_out", s, e.sum);
          bits = '0;
          for (int i = 15; i >= 0; i--) begin
            bits[i] = sd_out;
            @(negedge clk);
          end
          check("sd_out word", bits, e.sat);
          check("sd_out idle", sd_out, 0);
        end
      end
    end
  end

  initial begin : stim
    smp_t s;
    int   g;

    repeat (3) @(negedge clk);
    rst_check("reset");
    reset = 1'b0;

    // F0: only channel 0 enabled
    s = '{default: 16'h0123};
    s[0] = 16'h1000;
    s[1] = 16'h0000;
    frame(s, 32'h1000, 1'b1);
    for (int c = 1; c < 8; c++) cfg(c, 0, 1'b0);

    s = '{default: 16'h7FFF};
    s[0] = 16'h0800;
    s[1] = 16'h0000;
    frame(s, 32'h0800, 1'b1);

    // Impulse on channel 1, delay 3
    s = '{default: 16'h4444};
    s[1] = 16'h7FFF;
    frame(s, 0, 1'b1);
    cfg(0, 0, 1'b0);
    cfg(1, 3, 1'b1);
    s = '{default: 16'h1111};
    frame(s, 0, 1'b1);
    frame(s, 0, 1'b1);
    frame(s, 32767, 1'b1);

    // Full-scale sums and saturation boundaries
    s = '{default: 16'h7FFF};
    frame(s, 262136, 1'b1);
    for (int c = 0; c < 8; c++) cfg(c, 0, 1'b1);
    s = '{default: 16'h8000};
    frame(s, -262144, 1'b1);
    s = '{16'h0001, 16'hFFFF, 16'h0100, 16'h0200,
          16'h8000, 16'h7FFF, 16'h0010, 16'h0000};
    frame(s, 783, 1'b1);
    s = '{default: 16'hF000};
    frame(s, -32768, 1'b1);
    s = '{default: 16'h0000};
    s[0] = 16'h8000;
    s[1] = 16'hFFFF;
    frame(s, -32769, 1'b1);
    s = '{default: 16'h0000};
    s[0] = 16'h7FFF;
    s[1] = 16'h0001;
    frame(s, 32768, 1'b1);

    // Config timing: mid-frame write vs frame-end-cycle write
    s = '{default: 16'h5555};
    s[0] = 16'h0C00;
    frame(s, 32'h0C00, 1'b1);
    for (int c = 1; c < 8; c++) cfg(c, 0, 1'b0);
    s[0] = 16'h0D00;
    frame(s, 32'h0C00, 1'b1);
    cfg(0, 1, 1'b1);
    s[0] = 16'h0E00;
    frame(s, 32'h0D00, 1'b1);
    cfg_end(0, 2, 1'b1);
    s[0] = 16'h0F00;
    frame(s, 32'h0D00, 1'b1);

    // Reset mid-frame: frame aborted, no sum for it
    s[0] = 16'h6000;
    frame(s, 0, 1'b0);
    wait_pos(40);
    reset = 1'b1;
    @(negedge clk);
    rst_check("mid reset");
    reset = 1'b0;

    // Ramp with delay 15 across the write-pointer wrap
    for (int k = 0; k < 20; k++) begin
      s = '{default: 16'h3333};
      s[0] = ramp(k);
      frame(s, (k >= 15) ? int'(ramp(k - 15)) : 0, 1'b1);
      if (k == 0) begin
        cfg(0, 15, 1'b1);
        for (int c = 1; c < 8; c++) cfg(c, 0, 1'b0);
      end
    end

    g = 0;
    while (exq.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d sums pending, expected 0", exq.size());
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
